// File: rtl/cache_wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cache_wb_pkg
//  Description : Shared state encodings, geometry helpers and address-field
//                extraction for the write-back cache controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package cache_wb_pkg;

  // Controller state encoding
  localparam logic [2:0] c_S_IDLE    = 3'd0;
  localparam logic [2:0] c_S_LOOKUP  = 3'd1;
  localparam logic [2:0] c_S_WB_RD   = 3'd2;
  localparam logic [2:0] c_S_WB_MEM  = 3'd3;
  localparam logic [2:0] c_S_RF_MEM  = 3'd4;
  localparam logic [2:0] c_S_FL_SCAN = 3'd5;

  // Tag width left over after index and offset are removed
  function automatic int calc_tag_width(int addr_w, int index_w, int offset_w);
    return addr_w - index_w - offset_w;
  endfunction

  function automatic int calc_lines(int index_w);
    return 1 << index_w;
  endfunction

  function automatic int calc_words(int offset_w);
    return 1 << offset_w;
  endfunction

  // Extract a right-justified bit field from a word address
  function automatic logic [31:0] addr_field(logic [31:0] addr, int lsb, int width);
    return (addr >> lsb) & ((32'h1 << width) - 32'h1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_data_sram.sv
`default_nettype none
// ============================================================================
//  Module      : cache_data_sram
//  Description : Single-port synchronous data SRAM, one-cycle registered read,
//                write-enable selects write over read.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_data_sram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [ADDR_BITS-1:0]  i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_BITS];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Write or read one word per enabled cycle; read data holds otherwise
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
      else      r_rdata       <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/cache_wb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cache_wb_ctrl
//  Description : Direct-mapped write-back cache controller with multi-word
//                lines, per-line dirty bits, burst writeback/refill over a
//                strobe/ack memory port and whole-cache flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_wb_ctrl
  import cache_wb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int INDEX_WIDTH  = 3,
  parameter int OFFSET_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] Address_cpu,
  input  logic                  wr_rd_cpu,
  input  logic                  cs_cpu,
  input  logic [DATA_WIDTH-1:0] DOut_cpu,
  input  logic                  flush_cpu,
  output logic [DATA_WIDTH-1:0] din_cpu,
  output logic                  rdy_cpu,
  output logic [ADDR_WIDTH-1:0] Address_sdram,
  output logic                  wr_rd_sdram,
  output logic                  mstrb_sdram,
  output logic [DATA_WIDTH-1:0] din_sdram,
  input  logic [DATA_WIDTH-1:0] DOut_sdram,
  input  logic                  ack_sdram
);

  localparam int c_TAG_W   = calc_tag_width(ADDR_WIDTH, INDEX_WIDTH, OFFSET_WIDTH);
  localparam int c_LINES   = calc_lines(INDEX_WIDTH);
  localparam int c_SRAM_AW = INDEX_WIDTH + OFFSET_WIDTH;

  generate
    if (c_TAG_W < 1) begin : g_tag_check
      $error("cache_wb_ctrl: ADDR_WIDTH must exceed INDEX_WIDTH+OFFSET_WIDTH");
    end
  endgenerate

  logic [2:0]              r_state;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_wr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [INDEX_WIDTH-1:0]  r_line;
  logic [OFFSET_WIDTH-1:0] r_cnt;
  logic [INDEX_WIDTH-1:0]  r_ptr;
  logic                    r_flush_path;
  logic                    r_replay;
  logic                    r_ack_q;
  logic [DATA_WIDTH-1:0]   r_din_cpu;
  logic [c_LINES-1:0]      r_valid;
  logic [c_LINES-1:0]      r_dirty;
  logic [c_TAG_W-1:0]      r_tag [c_LINES];

  logic [c_TAG_W-1:0]      w_req_tag;
  logic [INDEX_WIDTH-1:0]  w_req_idx;
  logic [OFFSET_WIDTH-1:0] w_req_off;
  logic                    w_hit;
  logic                    w_mem_req;
  logic                    w_mem_ack;
  logic                    w_cnt_last;
  logic                    w_sram_en;
  logic                    w_sram_we;
  logic [c_SRAM_AW-1:0]    w_sram_addr;
  logic [DATA_WIDTH-1:0]   w_sram_wdata;
  logic [DATA_WIDTH-1:0]   w_sram_rdata;

  assign w_req_tag = c_TAG_W'(addr_field(32'(r_addr), INDEX_WIDTH + OFFSET_WIDTH, c_TAG_W));
  assign w_req_idx = INDEX_WIDTH'(addr_field(32'(r_addr), OFFSET_WIDTH, INDEX_WIDTH));
  assign w_req_off = OFFSET_WIDTH'(addr_field(32'(r_addr), 0, OFFSET_WIDTH));

  assign w_hit      = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);
  assign w_cnt_last = &r_cnt;

  // The strobe is suppressed for one cycle after every ack so each word is a
  // distinct request; stray acks while the strobe is low are ignored.
  assign w_mem_req = ((r_state == c_S_WB_MEM) || (r_state == c_S_RF_MEM)) && !r_ack_q;
  assign w_mem_ack = w_mem_req && ack_sdram;

  assign rdy_cpu     = (r_state == c_S_IDLE);
  assign din_cpu     = r_din_cpu;
  assign mstrb_sdram = w_mem_req;
  assign wr_rd_sdram = (r_state == c_S_WB_MEM);

  // Memory address/data are derived from registered state only, so they stay
  // stable for the whole strobe and fall to zero outside a burst.
  always_comb begin
    Address_sdram = '0;
    din_sdram     = '0;
    if (r_state == c_S_WB_MEM) begin
      Address_sdram = {r_tag[r_line], r_line, r_cnt};
      din_sdram     = w_sram_rdata;
    end else if (r_state == c_S_RF_MEM) begin
      Address_sdram = {w_req_tag, r_line, r_cnt};
    end
  end

  // Data SRAM port arbitration: one access per cycle chosen by the FSM state
  always_comb begin
    w_sram_en    = 1'b0;
    w_sram_we    = 1'b0;
    w_sram_addr  = '0;
    w_sram_wdata = r_wdata;
    case (r_state)
      c_S_IDLE: begin
        if (!flush_cpu && cs_cpu) begin
          w_sram_en   = 1'b1;
          w_sram_addr = Address_cpu[c_SRAM_AW-1:0];
        end
      end
      c_S_LOOKUP: begin
        if (r_replay) begin
          w_sram_en   = 1'b1;
          w_sram_addr = {w_req_idx, w_req_off};
        end else if (w_hit && r_wr) begin
          w_sram_en   = 1'b1;
          w_sram_we   = 1'b1;
          w_sram_addr = {w_req_idx, w_req_off};
        end
      end
      c_S_WB_RD: begin
        w_sram_en   = 1'b1;
        w_sram_addr = {r_line, r_cnt};
      end
      c_S_RF_MEM: begin
        if (w_mem_ack) begin
          w_sram_en    = 1'b1;
          w_sram_we    = 1'b1;
          w_sram_addr  = {r_line, r_cnt};
          w_sram_wdata = DOut_sdram;
        end
      end
      default: ;
    endcase
  end

  cache_data_sram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (c_SRAM_AW)
  ) u_sram (
    .clk     (clk),
    .i_en    (w_sram_en),
    .i_we    (w_sram_we),
    .i_addr  (w_sram_addr),
    .i_wdata (w_sram_wdata),
    .o_rdata (w_sram_rdata)
  );

  // Controller FSM with tag/valid/dirty bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= c_S_IDLE;
      r_addr       <= '0;
      r_wr         <= 1'b0;
      r_wdata      <= '0;
      r_line       <= '0;
      r_cnt        <= '0;
      r_ptr        <= '0;
      r_flush_path <= 1'b0;
      r_replay     <= 1'b0;
      r_ack_q      <= 1'b0;
      r_din_cpu    <= '0;
      r_valid      <= '0;
      r_dirty      <= '0;
      for (int i = 0; i < c_LINES; i++) r_tag[i] <= '0;
    end else begin
      r_ack_q <= w_mem_ack;
      case (r_state)
        c_S_IDLE: begin
          if (flush_cpu) begin
            r_ptr   <= '0;
            r_state <= c_S_FL_SCAN;
          end else if (cs_cpu) begin
            r_addr   <= Address_cpu;
            r_wr     <= wr_rd_cpu;
            r_wdata  <= DOut_cpu;
            r_replay <= 1'b0;
            r_state  <= c_S_LOOKUP;
          end
        end
        c_S_LOOKUP: begin
          if (r_replay) begin
            // Last refill word was written last cycle; re-read before compare
            r_replay <= 1'b0;
          end else if (w_hit) begin
            if (r_wr) r_dirty[w_req_idx] <= 1'b1;
            else      r_din_cpu          <= w_sram_rdata;
            r_state <= c_S_IDLE;
          end else begin
            r_line       <= w_req_idx;
            r_cnt        <= '0;
            r_flush_path <= 1'b0;
            r_state      <= (r_valid[w_req_idx] && r_dirty[w_req_idx]) ? c_S_WB_RD : c_S_RF_MEM;
          end
        end
        c_S_WB_RD: begin
          r_state <= c_S_WB_MEM;
        end
        c_S_WB_MEM: begin
          if (w_mem_ack) begin
            if (w_cnt_last) begin
              r_dirty[r_line] <= 1'b0;
              r_cnt           <= '0;
              r_state         <= r_flush_path ? c_S_FL_SCAN : c_S_RF_MEM;
            end else begin
              r_cnt   <= r_cnt + 1'b1;
              r_state <= c_S_WB_RD;
            end
          end
        end
        c_S_RF_MEM: begin
          if (w_mem_ack) begin
            if (w_cnt_last) begin
              r_tag[r_line]   <= w_req_tag;
              r_valid[r_line] <= 1'b1;
              r_dirty[r_line] <= 1'b0;
              r_cnt           <= '0;
              r_replay        <= 1'b1;
              r_state         <= c_S_LOOKUP;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        c_S_FL_SCAN: begin
          if (r_valid[r_ptr] && r_dirty[r_ptr]) begin
            // Write the line back, then revisit it here to invalidate it
            r_line       <= r_ptr;
            r_cnt        <= '0;
            r_flush_path <= 1'b1;
            r_state      <= c_S_WB_RD;
          end else begin
            r_valid[r_ptr] <= 1'b0;
            r_dirty[r_ptr] <= 1'b0;
            if (&r_ptr) begin
              r_ptr   <= '0;
              r_state <= c_S_IDLE;
            end else begin
              r_ptr <= r_ptr + 1'b1;
            end
          end
        end
        default: r_state <= c_S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_wb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_wb_ctrl
//  Description : Scoreboard bench for cache_wb_ctrl with an SDRAM model of
//                programmable ack latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Address_cpu;
  logic        wr_rd_cpu;
  logic        cs_cpu;
  logic [7:0]  DOut_cpu;
  logic        flush_cpu;
  logic [7:0]  din_cpu;
  logic        rdy_cpu;
  logic [15:0] Address_sdram;
  logic        wr_rd_sdram;
  logic        mstrb_sdram;
  logic [7:0]  din_sdram;
  logic [7:0]  DOut_sdram;
  logic        ack_sdram;

  cache_wb_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .Address_cpu   (Address_cpu),
    .wr_rd_cpu     (wr_rd_cpu),
    .cs_cpu        (cs_cpu),
    .DOut_cpu      (DOut_cpu),
    .flush_cpu     (flush_cpu),
    .din_cpu       (din_cpu),
    .rdy_cpu       (rdy_cpu),
    .Address_sdram (Address_sdram),
    .wr_rd_sdram   (wr_rd_sdram),
    .mstrb_sdram   (mstrb_sdram),
    .din_sdram     (din_sdram),
    .DOut_sdram    (DOut_sdram),
    .ack_sdram     (ack_sdram)
  );

  initial forever #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int lat         = 3;

  logic [7:0]  mem [65536];
  logic [15:0] rd_log[$];
  logic [15:0] wr_addr_log[$];
  logic [7:0]  wr_data_log[$];

  typedef struct {
    bit         is_read;
    logic [7:0] data;
    string      name;
  } exp_t;
  exp_t sb_q[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(logic [15:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  // SDRAM model: acks 'lat' cycles after the strobe is first seen
  initial begin : mem_model
    int          wcnt;
    logic [15:0] s_addr;
    logic [7:0]  s_data;
    bit          s_wr;
    bit          unstable;
    wcnt = 0; unstable = 0; s_addr = '0; s_data = '0; s_wr = 0;
    ack_sdram = 1'b0; DOut_sdram = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ack_sdram = 1'b0; wcnt = 0; unstable = 0;
      end else if (ack_sdram) begin
        ack_sdram = 1'b0; wcnt = 0;
        check("mstrb_drop_after_ack", {31'd0, mstrb_sdram}, 32'd0);
      end else if (mstrb_sdram) begin
        if (wcnt == 0) begin
          s_addr = Address_sdram; s_data = din_sdram; s_wr = wr_rd_sdram; unstable = 0;
        end else if (Address_sdram !== s_addr || wr_rd_sdram !== s_wr ||
                     (s_wr && din_sdram !== s_data)) begin
          unstable = 1;
        end
        if (wcnt >= lat) begin
          check("strobe_stable", {31'd0, unstable}, 32'd0);
          ack_sdram = 1'b1;
          if (s_wr) begin
            mem[s_addr] = s_data;
            wr_addr_log.push_back(s_addr);
            wr_data_log.push_back(s_data);
          end else begin
            DOut_sdram = mem[s_addr];
            rd_log.push_back(s_addr);
          end
        end
        wcnt++;
      end
    end
  end

  // Monitor: every return of rdy_cpu completes the oldest queued request
  initial begin : monitor
    bit   prev_rdy;
    exp_t e;
    prev_rdy = 1;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_rdy = 1;
      end else begin
        if (rdy_cpu && !prev_rdy) begin
          if (sb_q.size() == 0) begin
            check("unexpected_completion", 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            if (e.is_read) check(e.name, {24'd0, din_cpu}, {24'd0, e.data});
          end
        end
        prev_rdy = rdy_cpu;
      end
    end
  end

  task automatic clear_logs();
    rd_log.delete(); wr_addr_log.delete(); wr_data_log.delete();
  endtask

  task automatic issue(logic [15:0] a, bit wr, logic [7:0] d, bit cs, bit fl,
                       bit is_rd, logic [7:0] e, string n);
    int t;
    t = 0;
    while (!rdy_cpu && t < 2000) begin @(negedge clk); t++; end
    Address_cpu = a; wr_rd_cpu = wr; DOut_cpu = d; cs_cpu = cs; flush_cpu = fl;
    sb_q.push_back('{is_rd, e, n});
    @(negedge clk);
    cs_cpu = 1'b0; flush_cpu = 1'b0;
    check({n, "_rdy_fall"}, {31'd0, rdy_cpu}, 32'd0);
  endtask

  task automatic wait_done(string n, output int cyc);
    cyc = 1;
    while (!rdy_cpu && cyc < 5000) begin @(negedge clk); cyc++; end
    if (!rdy_cpu) check({n, "_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic check_reads(string n, logic [15:0] base, int count);
    bit ok;
    check({n, "_rd_count"}, rd_log.size(), count);
    ok = (rd_log.size() == count);
    for (int i = 0; i < rd_log.size() && i < count; i++)
      if (rd_log[i] !== base + 16'(i)) ok = 0;
    if (count > 0) check({n, "_rd_addr_seq"}, {31'd0, ok}, 32'd1);
  endtask

  // Writeback of one line: sequential addresses, one word may be modified
  task automatic check_wb(string n, logic [15:0] base, logic [15:0] sp_a, logic [7:0] sp_d);
    bit ok;
    check({n, "_wr_count"}, wr_addr_log.size(), 32);
    ok = (wr_addr_log.size() == 32);
    for (int i = 0; i < wr_addr_log.size() && i < 32; i++) begin
      if (wr_addr_log[i] !== base + 16'(i)) ok = 0;
      if (wr_data_log[i] !== ((base + 16'(i) == sp_a) ? sp_d : pat(base + 16'(i)))) ok = 0;
    end
    check({n, "_wr_seq_data"}, {31'd0, ok}, 32'd1);
  endtask

  task automatic rd(logic [15:0] a, logic [7:0] e, string n, output int cyc);
    clear_logs();
    issue(a, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, e, n);
    wait_done(n, cyc);
  endtask

  task automatic wr(logic [15:0] a, logic [7:0] d, string n, output int cyc);
    clear_logs();
    issue(a, 1'b1, d, 1'b1, 1'b0, 1'b0, 8'h00, n);
    wait_done(n, cyc);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int cyc;
    int t;
    for (int i = 0; i < 65536; i++) mem[i] = pat(16'(i));
    rst = 1'b1; Address_cpu = '0; wr_rd_cpu = 0; cs_cpu = 0; DOut_cpu = '0; flush_cpu = 0;
    repeat (3) @(negedge clk);
    check("rst_rdy",   {31'd0, rdy_cpu},     32'd1);
    check("rst_din",   {24'd0, din_cpu},     32'd0);
    check("rst_mstrb", {31'd0, mstrb_sdram}, 32'd0);
    check("rst_wr_rd", {31'd0, wr_rd_sdram}, 32'd0);
    check("rst_addr",  {16'd0, Address_sdram}, 32'd0);
    check("rst_dsd",   {24'd0, din_sdram},   32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Cold read miss, then hit in the same line
    rd(16'h1234, 8'h26, "cold_read", cyc);
    check_reads("cold_read", 16'h1220, 32);
    check("cold_read_no_wr", wr_addr_log.size(), 0);
    rd(16'h1235, 8'h27, "hit_read", cyc);
    check("hit_read_cycles", cyc, 2);
    check("hit_read_no_mem", rd_log.size() + wr_addr_log.size(), 0);

    // Write hit, then conflicting read forces writeback + refill
    wr(16'h1234, 8'hA5, "hit_write", cyc);
    check("hit_write_cycles", cyc, 2);
    check("hit_write_no_mem", rd_log.size() + wr_addr_log.size(), 0);
    rd(16'h5234, 8'h66, "dirty_miss", cyc);
    check_wb("dirty_miss", 16'h1220, 16'h1234, 8'hA5);
    check_reads("dirty_miss", 16'h5220, 32);
    rd(16'h1234, 8'hA5, "reread_wb", cyc);
    check_reads("reread_wb", 16'h1220, 32);
    check("reread_wb_no_wr", wr_addr_log.size(), 0);

    // Dirty lines 1 and 6, then flush
    wr(16'h1230, 8'h11, "dirty_l1", cyc);
    wr(16'h20C5, 8'h77, "write_miss_l6", cyc);
    check_reads("write_miss_l6", 16'h20C0, 32);
    clear_logs();
    issue(16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, "flush");
    wait_done("flush", cyc);
    check("flush_wr_count", wr_addr_log.size(), 64);
    check("flush_rd_count", rd_log.size(), 0);
    if (wr_addr_log.size() == 64) begin
      check("flush_l1_first", {16'd0, wr_addr_log[0]},  32'h1220);
      check("flush_l1_last",  {16'd0, wr_addr_log[31]}, 32'h123F);
      check("flush_l6_first", {16'd0, wr_addr_log[32]}, 32'h20C0);
      check("flush_l6_last",  {16'd0, wr_addr_log[63]}, 32'h20DF);
      check("flush_d_1230",   {24'd0, wr_data_log[16]}, 32'h11);
      check("flush_d_1234",   {24'd0, wr_data_log[20]}, 32'hA5);
      check("flush_d_20c5",   {24'd0, wr_data_log[37]}, 32'h77);
    end
    rd(16'h1235, 8'h27, "post_flush", cyc);
    check_reads("post_flush", 16'h1220, 32);

    // Flush and request together: flush wins, request dropped
    clear_logs();
    issue(16'h1235, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, "flush_cs");
    wait_done("flush_cs", cyc);
    check("flush_cs_no_mem", rd_log.size() + wr_addr_log.size(), 0);
    rd(16'h1235, 8'h27, "flush_cs_replay", cyc);
    check_reads("flush_cs_replay", 16'h1220, 32);

    // Reset during refill
    clear_logs();
    issue(16'h3300, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33, "abort");
    t = 0;
    while (rd_log.size() < 10 && t < 2000) begin @(negedge clk); t++; end
    check("abort_reached_word10", {31'd0, rd_log.size() >= 10}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_rdy",   {31'd0, rdy_cpu},       32'd1);
    check("abort_din",   {24'd0, din_cpu},       32'd0);
    check("abort_mstrb", {31'd0, mstrb_sdram},   32'd0);
    check("abort_addr",  {16'd0, Address_sdram}, 32'd0);
    check("abort_dsd",   {24'd0, din_sdram},     32'd0);
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    rd(16'h3300, 8'h33, "after_abort", cyc);
    check_reads("after_abort", 16'h3300, 32);

    // Zero extra ack latency, then 7 cycles
    lat = 0;
    rd(16'h4456, 8'h12, "lat0_read", cyc);
    check_reads("lat0_read", 16'h4440, 32);
    wr(16'h4457, 8'h9C, "lat0_write", cyc);
    lat = 7;
    rd(16'h6457, 8'h33, "lat7_dirty", cyc);
    check_wb("lat7_dirty", 16'h4440, 16'h4457, 8'h9C);
    check_reads("lat7_dirty", 16'h6440, 32);
    rd(16'h4457, 8'h9C, "lat7_reread", cyc);
    check_reads("lat7_reread", 16'h4440, 32);

    check("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
